if_fetch: RTL and testbench

//  Instruction-fetch stage; the producer side of the IF->ID hand-off. It reads each 32-bit

---
 rtl/if_fetch_if.sv | 26 ++
 rtl/if_fetch.sv | 92 +++++++++
 tb/tb_if_fetch.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// IF-stage bus bundle: byte-wide memory read port, IF->ID hand-off and the ID redirect.
// The master side is the fetch stage; the slave side is the memory controller plus IF_ID/ID.
interface if_fetch_if #(
    parameter int ADDR_W = 17
);
    logic              hold;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_busy;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_inst;
    logic              if_valid;

    modport master (
        input  hold, br_taken, br_addr, mem_busy, mem_rdata,
        output mem_re, mem_addr, if_pc, if_inst, if_valid
    );

    modport slave (
        output hold, br_taken, br_addr, mem_busy, mem_rdata,
        input  mem_re, mem_addr, if_pc, if_inst, if_valid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per instruction, assembled little-endian and presented
// to IF_ID; bubbles (all zero) while incomplete, restart on redirect from ID.
module if_fetch #(
    parameter int              ADDR_W   = 17,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    if_fetch_if.master    bus
);
    logic [ADDR_W-1:0] pc;
    logic [2:0]        cnt;
    logic [1:0]        rcv;
    logic              pend;
    logic [23:0]       byte_buf;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       out_inst;

    logic mem_re;
    logic accept;
    logic complete;
    logic consume;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        mem_re   = rdy & ~rst & ~bus.br_taken & (cnt < 3'd4) & ~(out_valid & bus.hold);
        accept   = mem_re & ~bus.mem_busy;
        complete = pend & (rcv == 2'd3);
        consume  = out_valid & ~bus.hold & ~complete;
    end

    assign bus.mem_re   = mem_re;
    assign bus.mem_addr = pc + ADDR_W'(cnt);
    assign bus.if_valid = out_valid;
    assign bus.if_pc    = out_pc;
    assign bus.if_inst  = out_inst;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            cnt       <= '0;
            rcv       <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else if (rdy) begin
            if (bus.br_taken) begin
                // Redirect discards any byte still in flight by dropping pend.
                pc        <= bus.br_addr;
                cnt       <= '0;
                rcv       <= '0;
                pend      <= 1'b0;
                out_valid <= 1'b0;
                out_pc    <= '0;
                out_inst  <= '0;
            end else begin
                pend <= accept;
                if (complete) begin
                    out_inst  <= {bus.mem_rdata, byte_buf};
                    out_pc    <= pc;
                    out_valid <= 1'b1;
                    pc        <= pc + ADDR_W'(4);
                    cnt       <= '0;
                    rcv       <= '0;
                end else begin
                    if (accept) cnt <= cnt + 3'd1;
                    if (pend)   rcv <= rcv + 2'd1;
                    if (consume) begin
                        out_valid <= 1'b0;
                        out_pc    <= '0;
                        out_inst  <= '0;
                    end
                end
            end
        end
    end

    // NOTE: the byte buffer has no reset; each slot is rewritten before it can reach if_inst.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !bus.br_taken && pend && !complete) begin
            case (rcv)
                2'd0:    byte_buf[7:0]   <= bus.mem_rdata;
                2'd1:    byte_buf[15:8]  <= bus.mem_rdata;
                default: byte_buf[23:16] <= bus.mem_rdata;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: expected requests and instructions are queued per scenario,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_if_fetch;
    localparam int AW = 17;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } req_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   inst;
        int            cyc;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;

    if_fetch_if #(.ADDR_W(AW)) bus ();

    if_fetch #(.ADDR_W(AW), .RESET_PC(17'h0)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    int   cyc = 0;
    int   t0  = 0;
    int   checks = 0;
    int   failures = 0;
    req_t exp_req[$];
    out_t exp_out[$];
    logic prev_stay = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide memory controller: data the cycle after an accepted request, held otherwise.
    always @(posedge clk) begin
        if (bus.mem_re && !bus.mem_busy) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_re && !bus.mem_busy) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_extra: got addr %h at cycle %0d, none expected", bus.mem_addr, cyc - t0);
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("req_addr", 32'(bus.mem_addr), 32'(r.addr));
                    check("req_cycle", 32'(cyc - t0), 32'(r.cyc));
                end
            end
            if (bus.if_valid && !prev_stay) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra: got pc %h inst %h at cycle %0d, none expected", bus.if_pc, bus.if_inst, cyc - t0);
                end else begin
                    out_t o;
                    o = exp_out.pop_front();
                    check("out_pc", 32'(bus.if_pc), 32'(o.pc));
                    check("out_inst", bus.if_inst, o.inst);
                    check("out_cycle", 32'(cyc - t0), 32'(o.cyc));
                end
            end
        end
        prev_stay = bus.if_valid && !rst && !bus.br_taken && (bus.hold || !rdy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int k);
        while ((cyc - t0) < k) step();
    endtask

    task automatic load4(input logic [AW-1:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + AW'(i)] = w[8*i +: 8];
    endtask

    task automatic push_req(input logic [AW-1:0] a, input int c);
        req_t r;
        r.addr = a;
        r.cyc  = c;
        exp_req.push_back(r);
    endtask

    task automatic push_out(input logic [AW-1:0] p, input logic [31:0] w, input int c);
        out_t o;
        o.pc   = p;
        o.inst = w;
        o.cyc  = c;
        exp_out.push_back(o);
    endtask

    // First reset edge is taken with rdy low, so reset must override rdy.
    task automatic reset_dut();
        rst = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_addr  = '0;
        bus.hold     = 1'b0;
        bus.mem_busy = 1'b0;
        step();
        @(negedge clk);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_pc", 32'(bus.if_pc), 32'd0);
        check("rst_inst", bus.if_inst, 32'd0);
        check("rst_mem_re", 32'(bus.mem_re), 32'd0);
        rdy = 1'b1;
        step();
        rst = 1'b0;
        t0 = cyc;
    endtask

    task automatic finish_test(input string name);
        step();
        step();
        check({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
        check({name, "_out_left"}, 32'(exp_out.size()), 32'd0);
        exp_req.delete();
        exp_out.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.hold      = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_addr   = '0;
        bus.mem_busy  = 1'b0;

        // Basic fetch, then freeze with rdy low while the instruction is presented.
        load4(17'h0, 32'h0000_0013);
        reset_dut();
        for (int i = 0; i < 4; i++) push_req(AW'(i), i);
        push_out(17'h0, 32'h0000_0013, 5);
        go_to(5);
        rdy = 1'b0;
        step();
        step();
        @(negedge clk);
        check("freeze_valid", 32'(bus.if_valid), 32'd1);
        check("freeze_inst", bus.if_inst, 32'h0000_0013);
        finish_test("basic");

        // Busy in cycle 2: byte 2 reissued.
        reset_dut();
        push_req(17'h0, 0); push_req(17'h1, 1); push_req(17'h2, 3); push_req(17'h3, 4);
        push_out(17'h0, 32'h0000_0013, 6);
        go_to(2);
        bus.mem_busy = 1'b1;
        @(negedge clk);
        check("busy_re", 32'(bus.mem_re), 32'd1);
        check("busy_addr", 32'(bus.mem_addr), 32'h2);
        step();
        bus.mem_busy = 1'b0;
        go_to(6);
        rdy = 1'b0;
        finish_test("busy");

        // Redirect in cycle 2.
        load4(17'h100, 32'h0010_0093);
        reset_dut();
        push_req(17'h0, 0); push_req(17'h1, 1);
        for (int i = 0; i < 4; i++) push_req(17'h100 + AW'(i), 3 + i);
        push_out(17'h100, 32'h0010_0093, 8);
        go_to(2);
        bus.br_taken = 1'b1;
        bus.br_addr  = 17'h100;
        @(negedge clk);
        check("br_re", 32'(bus.mem_re), 32'd0);
        step();
        bus.br_taken = 1'b0;
        go_to(8);
        rdy = 1'b0;
        finish_test("redirect");

        // Hold while valid: outputs stable, no requests; release issues pc+4 same cycle.
        load4(17'h4, 32'h0010_0093);
        reset_dut();
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) push_req(AW'(i), i);
        push_out(17'h0, 32'h0000_0013, 5);
        push_req(17'h4, 8); push_req(17'h5, 9); push_req(17'h6, 10); push_req(17'h7, 11);
        push_out(17'h4, 32'h0010_0093, 13);
        go_to(7);
        @(negedge clk);
        check("hold_re", 32'(bus.mem_re), 32'd0);
        check("hold_valid", 32'(bus.if_valid), 32'd1);
        check("hold_inst", bus.if_inst, 32'h0000_0013);
        check("hold_pc", 32'(bus.if_pc), 32'h0);
        go_to(8);
        bus.hold = 1'b0;
        @(negedge clk);
        check("unhold_re", 32'(bus.mem_re), 32'd1);
        check("unhold_addr", 32'(bus.mem_addr), 32'h4);
        go_to(13);
        rdy = 1'b0;
        finish_test("hold");

        // rdy low for cycles 2..4 while byte 1 is in flight.
        load4(17'h0, 32'h1234_5678);
        reset_dut();
        push_req(17'h0, 0); push_req(17'h1, 1); push_req(17'h2, 5); push_req(17'h3, 6);
        push_out(17'h0, 32'h1234_5678, 8);
        go_to(2);
        rdy = 1'b0;
        go_to(3);
        @(negedge clk);
        check("rdy_re", 32'(bus.mem_re), 32'd0);
        go_to(5);
        rdy = 1'b1;
        go_to(8);
        rdy = 1'b0;
        finish_test("rdy");

        // Top-of-memory fetch, pc wrap to 0, then reset mid-fetch.
        load4(17'h1FFFC, 32'hDEAD_BEEF);
        reset_dut();
        for (int i = 0; i < 4; i++) push_req(17'h1FFFC + AW'(i), 1 + i);
        push_out(17'h1FFFC, 32'hDEAD_BEEF, 6);
        push_req(17'h0, 6); push_req(17'h1, 7);
        for (int i = 0; i < 4; i++) push_req(AW'(i), 9 + i);
        push_out(17'h0, 32'h1234_5678, 14);
        bus.br_taken = 1'b1;
        bus.br_addr  = 17'h1FFFC;
        step();
        bus.br_taken = 1'b0;
        go_to(8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        go_to(14);
        rdy = 1'b0;
        finish_test("wrap");

        // Byte addresses wrap inside one instruction.
        reset_dut();
        push_req(17'h1FFFE, 1); push_req(17'h1FFFF, 2); push_req(17'h0, 3); push_req(17'h1, 4);
        push_out(17'h1FFFE, 32'h5678_DEAD, 6);
        push_req(17'h2, 6);
        bus.br_taken = 1'b1;
        bus.br_addr  = 17'h1FFFE;
        step();
        bus.br_taken = 1'b0;
        go_to(7);
        rdy = 1'b0;
        finish_test("split");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
